param_onehot_sequencer: RTL and testbench



---
 rtl/param_onehot_sequencer.sv | 175 +++++++++++++++++
 tb/tb_param_onehot_sequencer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/param_onehot_sequencer.sv
// -----------------------------------------------------------------------------
// param_onehot_sequencer
//
// Purpose:
//   Registered binary-to-one-hot decoder of configurable width. Three run-time
//   modes share one address source:
//     hold  (mode 00) : en loads one-hot(in); otherwise out/addr hold.
//     pulse (mode 01) : en emits one-hot(in) for a single cycle; otherwise out=0.
//     sweep (mode 10) : start launches a walk from in to last (wrapping mod
//                       OUT_W), one address per enabled cycle, with busy/done.
//     mode 11 is reserved and forces out to zero.
//   out is always registered and always one-hot or all-zero.
//
// Optional feature:
//   ONEHOT_SEQ_STRIDE_EN - adds the stride port. The stride is latched at sweep
//   launch (0 is treated as 1) and the sweep advances by that step; it finishes
//   once the remaining distance to last is smaller than the step. Without the
//   macro the step is fixed at 1 and the sweep finishes at addr == last.
//
// Parameters:
//   IN_W  : address width, 1..12.
//   OUT_W : 2**IN_W, derived; do not override.
//
// Ports:
//   clk    : rising-edge clock.
//   rst_n  : asynchronous active-low reset (out/addr/busy/done to 0, FSM IDLE).
//   en     : load in hold/pulse modes, advance in sweep.
//   mode   : 00 hold, 01 pulse, 10 sweep, 11 reserved.
//   in     : decode address (hold/pulse) or sweep start address.
//   last   : sweep end address, sampled live while busy.
//   stride : sweep step (only with ONEHOT_SEQ_STRIDE_EN).
//   start  : sweep launch request, honoured only in IDLE with mode 10.
//   out    : registered one-hot or all-zero vector.
//   addr   : index currently (or most recently) driven on out.
//   busy   : high while the sweep FSM is in RUN.
//   done   : one-cycle pulse when a sweep completes.
// -----------------------------------------------------------------------------
module param_onehot_sequencer #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 2**IN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  in,
  input  logic [IN_W-1:0]  last,
`ifdef ONEHOT_SEQ_STRIDE_EN
  input  logic [IN_W-1:0]  stride,
`endif
  input  logic             start,
  output logic [OUT_W-1:0] out,
  output logic [IN_W-1:0]  addr,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_PULSE = 2'b01;
  localparam logic [1:0] MODE_SWEEP = 2'b10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t              state_p0;
  logic [OUT_W-1:0]    out_p0;
  logic [IN_W-1:0]     addr_p0;
  logic                busy_p0;
  logic                done_p0;

  logic [IN_W-1:0]     step;
  logic [IN_W-1:0]     next_addr;
  logic                sweep_end;

  function automatic logic [OUT_W-1:0] onehot(input logic [IN_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

`ifdef ONEHOT_SEQ_STRIDE_EN
  logic [IN_W-1:0]     step_p0;
  logic [IN_W-1:0]     launch_step;
  logic [IN_W-1:0]     dist;

  // A zero stride would never advance; treat it as a unit step.
  assign launch_step = (stride == '0) ? IN_W'(1) : stride;
  assign step        = step_p0;
  // Remaining distance to last, modulo OUT_W via natural IN_W wrap.
  assign dist        = last - addr_p0;
  assign sweep_end   = (dist < step);
`else
  assign step        = IN_W'(1);
  assign sweep_end   = (addr_p0 == last);
`endif

  assign next_addr = addr_p0 + step;

  // Stage p0: single registered stage driving all outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_p0 <= IDLE;
      out_p0   <= '0;
      addr_p0  <= '0;
      busy_p0  <= 1'b0;
      done_p0  <= 1'b0;
`ifdef ONEHOT_SEQ_STRIDE_EN
      step_p0  <= IN_W'(1);
`endif
    end else begin
      done_p0 <= 1'b0;
      case (state_p0)
        IDLE: begin
          case (mode)
            MODE_HOLD: begin
              if (en) begin
                out_p0  <= onehot(in);
                addr_p0 <= in;
              end
            end
            MODE_PULSE: begin
              if (en) begin
                out_p0  <= onehot(in);
                addr_p0 <= in;
              end else begin
                out_p0  <= '0;
              end
            end
            MODE_SWEEP: begin
              // Without start the sweep mode simply holds the last outputs.
              if (start) begin
                state_p0 <= RUN;
                busy_p0  <= 1'b1;
                out_p0   <= onehot(in);
                addr_p0  <= in;
`ifdef ONEHOT_SEQ_STRIDE_EN
                step_p0  <= launch_step;
`endif
              end
            end
            default: begin
              out_p0 <= '0;
            end
          endcase
        end
        RUN: begin
          // mode, in and start are ignored here; a start is dropped, not queued.
          if (en) begin
            if (sweep_end) begin
              state_p0 <= IDLE;
              busy_p0  <= 1'b0;
              done_p0  <= 1'b1;
              out_p0   <= '0;
            end else begin
              addr_p0  <= next_addr;
              out_p0   <= onehot(next_addr);
            end
          end
        end
        default: begin
          state_p0 <= IDLE;
          busy_p0  <= 1'b0;
          out_p0   <= '0;
        end
      endcase
    end
  end

  assign out  = out_p0;
  assign addr = addr_p0;
  assign busy = busy_p0;
  assign done = done_p0;

endmodule

// File: tb/tb_param_onehot_sequencer.sv
// -----------------------------------------------------------------------------
// tb_param_onehot_sequencer
//
// Self-checking bench for param_onehot_sequencer with IN_W = 9. Each driven
// cycle pushes its expected post-edge outputs onto a scoreboard queue; the
// entry is popped and compared one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_param_onehot_sequencer;

  localparam int IN_W  = 9;
  localparam int OUT_W = 512;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [1:0]       mode;
  logic [IN_W-1:0]  in;
  logic [IN_W-1:0]  last;
  logic             start;
  logic [OUT_W-1:0] out;
  logic [IN_W-1:0]  addr;
  logic             busy;
  logic             done;
`ifdef ONEHOT_SEQ_STRIDE_EN
  logic [IN_W-1:0]  stride;
`endif

  typedef struct {
    logic [OUT_W-1:0] out;
    logic [IN_W-1:0]  addr;
    logic             busy;
    logic             done;
  } exp_t;

  exp_t  sbq[$];
  int    n_chk;
  int    n_fail;
  string tname;

  param_onehot_sequencer #(.IN_W(IN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .in    (in),
    .last  (last),
`ifdef ONEHOT_SEQ_STRIDE_EN
    .stride(stride),
`endif
    .start (start),
    .out   (out),
    .addr  (addr),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] oh(input int i);
    logic [OUT_W-1:0] one;
    one = {{(OUT_W-1){1'b0}}, 1'b1};
    oh  = one << i;
  endfunction

  task automatic chk(input string tag, input logic [OUT_W-1:0] got,
                     input logic [OUT_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle; x_idx < 0 means out is expected all-zero.
  task automatic cyc(input logic e, input logic [1:0] m, input int a, input int l,
                     input logic s, input int x_idx, input int x_addr,
                     input logic x_busy, input logic x_done);
    exp_t x;
    en    = e;
    mode  = m;
    in    = IN_W'(a);
    last  = IN_W'(l);
    start = s;
    x.out  = (x_idx < 0) ? '0 : oh(x_idx);
    x.addr = IN_W'(x_addr);
    x.busy = x_busy;
    x.done = x_done;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    x = sbq.pop_front();
    chk({tname, ".out"},  out,  x.out);
    chk({tname, ".addr"}, OUT_W'(addr), OUT_W'(x.addr));
    chk({tname, ".busy"}, OUT_W'(busy), OUT_W'(x.busy));
    chk({tname, ".done"}, OUT_W'(done), OUT_W'(x.done));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst_n  = 1'b1;
    en     = 1'b0;
    mode   = 2'b00;
    in     = '0;
    last   = '0;
    start  = 1'b0;
`ifdef ONEHOT_SEQ_STRIDE_EN
    stride = '0;
`endif

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    tname = "reset";
    chk("reset.out",  out,  '0);
    chk("reset.addr", OUT_W'(addr), '0);
    chk("reset.busy", OUT_W'(busy), '0);
    chk("reset.done", OUT_W'(done), '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Hold: load 300 then hold for several cycles with a different in
    tname = "hold";
    cyc(1, 2'b00, 300, 0, 0, 300, 300, 0, 0);
    for (int k = 0; k < 5; k++) cyc(0, 2'b00, 17, 0, 0, 300, 300, 0, 0);

    // Pulse: 5, 6, 7 on consecutive cycles, then zero with addr held
    tname = "pulse";
    cyc(1, 2'b01, 5, 0, 0, 5, 5, 0, 0);
    cyc(1, 2'b01, 6, 0, 0, 6, 6, 0, 0);
    cyc(1, 2'b01, 7, 0, 0, 7, 7, 0, 0);
    cyc(0, 2'b01, 9, 0, 0, -1, 7, 0, 0);
    cyc(0, 2'b01, 9, 0, 0, -1, 7, 0, 0);

    // Reserved mode forces zero, addr holds
    tname = "resv";
    cyc(1, 2'b00, 42, 0, 0, 42, 42, 0, 0);
    cyc(1, 2'b11, 99, 0, 0, -1, 42, 0, 0);

    // Sweep with wrap: 510, 511, 0, 1, then done
    tname = "wrap";
    cyc(1, 2'b10, 510, 1, 1, 510, 510, 1, 0);
    cyc(1, 2'b10, 0,   1, 0, 511, 511, 1, 0);
    cyc(1, 2'b10, 0,   1, 0, 0,   0,   1, 0);
    cyc(1, 2'b10, 0,   1, 0, 1,   1,   1, 0);
    cyc(1, 2'b10, 0,   1, 0, -1,  1,   0, 1);
    cyc(0, 2'b10, 0,   1, 0, -1,  1,   0, 0);

    // Ignored start / mode change during RUN, then done+start on the same edge
    tname = "ignst";
    cyc(1, 2'b10, 0,   3, 1, 0, 0, 1, 0);
    cyc(1, 2'b00, 100, 3, 1, 1, 1, 1, 0);
    cyc(1, 2'b10, 100, 3, 1, 2, 2, 1, 0);
    cyc(1, 2'b10, 0,   3, 0, 3, 3, 1, 0);
    cyc(1, 2'b10, 200, 3, 1, -1, 3, 0, 1);
    tname = "single";
    cyc(1, 2'b10, 200, 200, 1, 200, 200, 1, 0);
    cyc(1, 2'b10, 0,   200, 0, -1,  200, 0, 1);
    cyc(0, 2'b10, 0,   200, 0, -1,  200, 0, 0);

    // Pause at addr 4, then asynchronous reset mid-cycle
    tname = "pause";
    cyc(1, 2'b10, 0, 20, 1, 0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) cyc(1, 2'b10, 0, 20, 0, k, k, 1, 0);
    for (int k = 0; k < 3; k++)  cyc(0, 2'b10, 0, 20, 0, 4, 4, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("areset.out",  out,  '0);
    chk("areset.addr", OUT_W'(addr), '0);
    chk("areset.busy", OUT_W'(busy), '0);
    chk("areset.done", OUT_W'(done), '0);
    @(negedge clk);
    rst_n = 1'b1;
    tname = "restart";
    cyc(1, 2'b10, 7, 8, 1, 7, 7, 1, 0);
    cyc(1, 2'b10, 0, 8, 0, 8, 8, 1, 0);
    cyc(1, 2'b10, 0, 8, 0, -1, 8, 0, 1);

`ifdef ONEHOT_SEQ_STRIDE_EN
    // Stride 4 latched at launch; later stride changes do not matter
    tname = "stride4";
    stride = 9'd4;
    cyc(1, 2'b10, 0, 10, 1, 0, 0, 1, 0);
    stride = 9'd9;
    cyc(1, 2'b10, 0, 10, 0, 4, 4, 1, 0);
    cyc(1, 2'b10, 0, 10, 0, 8, 8, 1, 0);
    cyc(1, 2'b10, 0, 10, 0, -1, 8, 0, 1);
    // Stride 0 behaves as 1: eleven addresses
    tname = "stride0";
    stride = 9'd0;
    cyc(1, 2'b10, 0, 10, 1, 0, 0, 1, 0);
    for (int k = 1; k <= 10; k++) cyc(1, 2'b10, 0, 10, 0, k, k, 1, 0);
    cyc(1, 2'b10, 0, 10, 0, -1, 10, 0, 1);
`endif

    chk("sb.empty", OUT_W'(sbq.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
